// File: rtl/hpdcache_l15_resp_router.sv
// Response router ahead of the L1.5 response demux: records the issuing port per transaction ID
// and steers buffered memory responses (2-entry FIFO) to that port.
module hpdcache_l15_resp_router #(
  parameter int unsigned N            = 2,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned PORTID_WIDTH = 1,
  parameter int unsigned RESP_WIDTH   = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  input  logic                      req_ready_i,
  input  logic [ID_WIDTH-1:0]       req_id_i,
  input  logic [PORTID_WIDTH-1:0]   req_portid_i,
  input  logic                      req_need_rsp_i,
  input  logic                      mem_resp_valid_i,
  output logic                      mem_resp_ready_o,
  input  logic [ID_WIDTH-1:0]       mem_resp_id_i,
  input  logic                      mem_resp_last_i,
  input  logic [RESP_WIDTH-1:0]     mem_resp_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [ID_WIDTH-1:0]       resp_id_o,
  output logic [RESP_WIDTH-1:0]     resp_o,
  output logic [PORTID_WIDTH-1:0]   resp_sel_o,
  output logic [2**ID_WIDTH-1:0]    id_busy_o,
  output logic [ID_WIDTH:0]         outstanding_o,
  output logic                      alloc_err_o,
  output logic                      unexp_err_o
);

  localparam int unsigned NumIds = 2 ** ID_WIDTH;
  localparam int unsigned CntW   = ID_WIDTH + 1;

  if (2 ** PORTID_WIDTH < N) begin : g_param_check
    $error("PORTID_WIDTH is too narrow to encode N ports");
  end

  // Routing table and allocation state
  logic [PORTID_WIDTH-1:0] table_q [NumIds];
  logic [PORTID_WIDTH-1:0] table_d [NumIds];
  logic [NumIds-1:0]       busy_q, busy_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    alloc_err_q, alloc_err_d;
  logic                    unexp_err_q, unexp_err_d;

  // Response FIFO
  logic [RESP_WIDTH-1:0]   fifo_data_q [2];
  logic [RESP_WIDTH-1:0]   fifo_data_d [2];
  logic [ID_WIDTH-1:0]     fifo_id_q [2];
  logic [ID_WIDTH-1:0]     fifo_id_d [2];
  logic [PORTID_WIDTH-1:0] fifo_sel_q [2];
  logic [PORTID_WIDTH-1:0] fifo_sel_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              fcnt_q, fcnt_d;

  logic accept, hit, free, alloc, same_id, inc, push, pop;

  always_comb begin
    accept  = mem_resp_valid_i & mem_resp_ready_o;
    hit     = accept & busy_q[mem_resp_id_i];
    free    = hit & mem_resp_last_i;
    alloc   = req_valid_i & req_ready_i & req_need_rsp_i;
    // A final beat freeing the very ID being reallocated is a clean handover, not a collision
    same_id = free & (mem_resp_id_i == req_id_i);
    inc     = alloc & (~busy_q[req_id_i] | same_id);
    push    = hit;
    pop     = resp_valid_o & resp_ready_i;
  end

  always_comb begin
    table_d = table_q;
    busy_d  = busy_q;
    if (free) begin
      busy_d[mem_resp_id_i] = 1'b0;
    end
    if (alloc) begin
      table_d[req_id_i] = req_portid_i;
      busy_d[req_id_i]  = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, free})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    alloc_err_d = alloc & busy_q[req_id_i] & ~same_id;
    unexp_err_d = accept & ~busy_q[mem_resp_id_i];
  end

  // The table is read with its registered value, so a same-cycle reallocation does not leak in
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    fifo_sel_d  = fifo_sel_q;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_resp_i;
      fifo_id_d[wr_ptr_q]   = mem_resp_id_i;
      fifo_sel_d[wr_ptr_q]  = table_q[mem_resp_id_i];
    end
    fcnt_d = fcnt_q;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        table_q[i] <= '0;
      end
      busy_q      <= '0;
      cnt_q       <= '0;
      alloc_err_q <= 1'b0;
      unexp_err_q <= 1'b0;
    end else begin
      table_q     <= table_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      alloc_err_q <= alloc_err_d;
      unexp_err_q <= unexp_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
        fifo_sel_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fcnt_q   <= 2'd0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
      fifo_sel_q  <= fifo_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  always_comb begin
    mem_resp_ready_o = (fcnt_q != 2'd2);
    resp_valid_o     = (fcnt_q != 2'd0);
    resp_o           = fifo_data_q[rd_ptr_q];
    resp_id_o        = fifo_id_q[rd_ptr_q];
    resp_sel_o       = fifo_sel_q[rd_ptr_q];
    id_busy_o        = busy_q;
    outstanding_o    = cnt_q;
    alloc_err_o      = alloc_err_q;
    unexp_err_o      = unexp_err_q;
  end

endmodule

// File: tb/tb_hpdcache_l15_resp_router.sv
// Bench for hpdcache_l15_resp_router: directed scenarios plus random traffic, checked against a
// queue-based reference model with a decoupled output monitor.
module tb_hpdcache_l15_resp_router;

  localparam int IDW = 4;
  localparam int PW  = 1;
  localparam int RW  = 64;
  localparam int NID = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req_valid_i, req_ready_i, req_need_rsp_i;
  logic [IDW-1:0]  req_id_i;
  logic [PW-1:0]   req_portid_i;
  logic            mem_resp_valid_i, mem_resp_last_i;
  logic            mem_resp_ready_o;
  logic [IDW-1:0]  mem_resp_id_i;
  logic [RW-1:0]   mem_resp_i;
  logic            resp_valid_o, resp_ready_i;
  logic [IDW-1:0]  resp_id_o;
  logic [RW-1:0]   resp_o;
  logic [PW-1:0]   resp_sel_o;
  logic [NID-1:0]  id_busy_o;
  logic [IDW:0]    outstanding_o;
  logic            alloc_err_o, unexp_err_o;

  hpdcache_l15_resp_router #(
    .N(2), .ID_WIDTH(IDW), .PORTID_WIDTH(PW), .RESP_WIDTH(RW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_i(req_ready_i), .req_id_i(req_id_i),
    .req_portid_i(req_portid_i), .req_need_rsp_i(req_need_rsp_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_id_i(mem_resp_id_i), .mem_resp_last_i(mem_resp_last_i), .mem_resp_i(mem_resp_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_o(resp_o), .resp_sel_o(resp_sel_o), .id_busy_o(id_busy_o),
    .outstanding_o(outstanding_o), .alloc_err_o(alloc_err_o), .unexp_err_o(unexp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: which port owns each ID, which IDs are live, FIFO occupancy, pending pulses
  logic [PW-1:0]        m_table [NID];
  bit                   m_busy  [NID];
  int                   m_cnt;
  bit                   m_aerr, m_uerr;
  logic [RW+IDW+PW-1:0] sb [$];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NID-1:0] busy_vec();
    logic [NID-1:0] v;
    for (int i = 0; i < NID; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NID; i++) begin
      m_table[i] = '0;
      m_busy[i]  = 1'b0;
    end
    m_cnt  = 0;
    m_aerr = 1'b0;
    m_uerr = 1'b0;
    sb.delete();
  endtask

  task automatic idle();
    req_valid_i      = 1'b0;
    req_ready_i      = 1'b0;
    req_need_rsp_i   = 1'b0;
    req_id_i         = '0;
    req_portid_i     = '0;
    mem_resp_valid_i = 1'b0;
    mem_resp_last_i  = 1'b0;
    mem_resp_id_i    = '0;
    mem_resp_i       = '0;
  endtask

  // Check registered outputs mid-cycle, then apply the rules for the inputs sampled at the edge
  task automatic tick();
    bit acc, pop, hit, alloc;
    int rid, aid;
    @(negedge clk_i);
    chk("mem_resp_ready", 64'(mem_resp_ready_o), 64'(m_cnt != 2));
    chk("resp_valid", 64'(resp_valid_o), 64'(m_cnt != 0));
    chk("id_busy", 64'(id_busy_o), 64'(busy_vec()));
    chk("outstanding", 64'(outstanding_o), 64'($countones(busy_vec())));
    chk("alloc_err", 64'(alloc_err_o), 64'(m_aerr));
    chk("unexp_err", 64'(unexp_err_o), 64'(m_uerr));
    @(posedge clk_i);
    rid    = int'(mem_resp_id_i);
    aid    = int'(req_id_i);
    acc    = mem_resp_valid_i && (m_cnt < 2);
    pop    = (m_cnt > 0) && resp_ready_i;
    hit    = acc && m_busy[rid];
    alloc  = req_valid_i && req_ready_i && req_need_rsp_i;
    m_uerr = acc && !m_busy[rid];
    m_aerr = alloc && m_busy[aid] && !(hit && mem_resp_last_i && rid == aid);
    if (hit) sb.push_back({mem_resp_i, mem_resp_id_i, m_table[rid]});
    if (hit && mem_resp_last_i) m_busy[rid] = 1'b0;
    if (alloc) begin
      m_busy[aid]  = 1'b1;
      m_table[aid] = req_portid_i;
    end
    m_cnt = m_cnt + int'(hit) - int'(pop);
    #1;
  endtask

  task automatic alloc_id(input int id, input int port);
    req_valid_i = 1'b1; req_ready_i = 1'b1; req_need_rsp_i = 1'b1;
    req_id_i = IDW'(id); req_portid_i = PW'(port);
    tick();
    req_valid_i = 1'b0; req_ready_i = 1'b0; req_need_rsp_i = 1'b0;
  endtask

  // Hold a beat until accepted; optionally raise resp_ready after rel stalled cycles
  task automatic send(input int id, input bit last, input logic [RW-1:0] d, input int rel);
    bit a;
    bit done = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_id_i = IDW'(id);
    mem_resp_last_i = last; mem_resp_i = d;
    for (int k = 0; k < 20 && !done; k++) begin
      if (rel >= 0 && k == rel) resp_ready_i = 1'b1;
      a = (m_cnt < 2);
      tick();
      done = a;
    end
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: beat id=%0d not accepted, required acceptance within 20 cycles",
               id);
    end
    mem_resp_valid_i = 1'b0; mem_resp_last_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    logic [RW+IDW+PW-1:0] e;
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_extra: got id=%0h sel=%0h data=%0h, required no output",
                 resp_id_o, resp_sel_o, resp_o);
      end else begin
        e = sb.pop_front();
        if ({resp_o, resp_id_o, resp_sel_o} !== e) begin
          errors++;
          $display("FAIL resp_beat: got data=%0h id=%0h sel=%0h, required data=%0h id=%0h sel=%0h",
                   resp_o, resp_id_o, resp_sel_o, e[RW+IDW+PW-1:IDW+PW], e[IDW+PW-1:PW],
                   e[PW-1:0]);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_ready"}, 64'(mem_resp_ready_o), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_resp"}, resp_o, 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id_o), 64'd0);
    chk({tag, "_resp_sel"}, 64'(resp_sel_o), 64'd0);
    chk({tag, "_busy"}, 64'(id_busy_o), 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    chk({tag, "_errs"}, 64'({alloc_err_o, unexp_err_o}), 64'd0);
  endtask

  initial begin
    int id;
    rst_ni = 1'b0;
    resp_ready_i = 1'b1;
    idle();
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // Single transaction
    alloc_id(3, 1);
    send(3, 1'b1, 64'hA5, -1);
    tick(); tick();

    // Multi-beat
    alloc_id(5, 0);
    for (int b = 0; b < 4; b++) send(5, b == 3, 64'h500 + 64'(b), -1);
    tick(); tick();

    // Backpressure: third beat stalls until ready returns
    alloc_id(6, 1);
    resp_ready_i = 1'b0;
    send(6, 1'b0, 64'h61, -1);
    send(6, 1'b0, 64'h62, -1);
    send(6, 1'b1, 64'h63, 2);
    tick(); tick(); tick();

    // Unexpected ID
    send(7, 1'b1, 64'h77, -1);
    tick(); tick();

    // Double allocation
    alloc_id(2, 0);
    alloc_id(2, 1);
    send(2, 1'b1, 64'h22, -1);
    tick(); tick();

    // Same-cycle free and reallocate of id 4
    alloc_id(4, 0);
    req_valid_i = 1'b1; req_ready_i = 1'b1; req_need_rsp_i = 1'b1;
    req_id_i = 4'd4; req_portid_i = 1'b1;
    send(4, 1'b1, 64'h40, -1);
    req_valid_i = 1'b0; req_ready_i = 1'b0; req_need_rsp_i = 1'b0;
    send(4, 1'b1, 64'h41, -1);
    tick(); tick();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      resp_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        req_valid_i = 1'b1; req_ready_i = $urandom_range(1); req_need_rsp_i = $urandom_range(1);
        req_id_i = IDW'($urandom_range(NID - 1)); req_portid_i = PW'($urandom_range(1));
      end
      if ($urandom_range(1) == 0) begin
        id = int'($urandom_range(NID - 1));
        for (int t = 0; t < 8 && $urandom_range(4) != 0; t++) begin
          if (m_busy[id]) break;
          id = int'($urandom_range(NID - 1));
        end
        mem_resp_valid_i = 1'b1; mem_resp_id_i = IDW'(id);
        mem_resp_last_i = ($urandom_range(2) == 0);
        mem_resp_i = {$urandom, $urandom};
      end
      tick();
    end

    // Reset with two entries queued
    idle();
    resp_ready_i = 1'b0;
    for (int i = 0; i < NID; i++) if (!m_busy[i]) alloc_id(i, 1);
    send(9, 1'b0, 64'h91, -1);
    send(9, 1'b0, 64'h92, -1);
    chk("prereset_full", 64'(m_cnt), 64'd2);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    tick();
    rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    alloc_id(1, 1);
    send(1, 1'b1, 64'h11, -1);

    // Drain
    idle();
    resp_ready_i = 1'b1;
    for (int k = 0; k < 10 && m_cnt != 0; k++) tick();
    tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_l15_resp_router.md
# hpdcache_l15_resp_router

Response routing stage placed directly upstream of the L1.5 response demultiplexer. It tracks, per transaction ID, which requester port issued each request that expects a response. It buffers incoming memory responses in a 2-entry FIFO and resolves their destination port from that table. It then presents response, ID and port select to the demux with a standard valid/ready handshake.

## Interface
Parameters:
- `N`, 2: number of requester ports.
- `ID_WIDTH`, 4: transaction ID width; the table has `2**ID_WIDTH` entries.
- `PORTID_WIDTH`, 1: port identifier width; must satisfy `2**PORTID_WIDTH >= N`.
- `RESP_WIDTH`, 64: response payload width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are `clk_i` and `rst_ni`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: snooped request valid.
- `req_ready_i` in 1: snooped request ready.
- `req_id_i` in ID_WIDTH: ID of the snooped request.
- `req_portid_i` in PORTID_WIDTH: issuing port of the snooped request.
- `req_need_rsp_i` in 1: the request expects a response.
- `mem_resp_valid_i` in 1: memory response valid.
- `mem_resp_ready_o` out 1: memory response ready.
- `mem_resp_id_i` in ID_WIDTH: memory response ID.
- `mem_resp_last_i` in 1: final beat of this transaction.
- `mem_resp_i` in RESP_WIDTH: response payload.
- `resp_valid_o` out 1: response valid toward the demux.
- `resp_ready_i` in 1: demux ready.
- `resp_id_o` out ID_WIDTH: forwarded response ID.
- `resp_o` out RESP_WIDTH: forwarded payload.
- `resp_sel_o` out PORTID_WIDTH: destination port, fed to the demux select.
- `id_busy_o` out 2**ID_WIDTH: per-ID allocated flags, for upstream ID allocation.
- `outstanding_o` out ID_WIDTH+1: number of allocated IDs.
- `alloc_err_o` out 1: one-cycle pulse; an allocation hit an already-busy ID.
- `unexp_err_o` out 1: one-cycle pulse; a response arrived for an unallocated ID.

## Operation
- **Allocate:** occurs on `req_valid_i & req_ready_i & req_need_rsp_i`. Writes `table[req_id_i] = req_portid_i` and sets `busy[req_id_i]`.
  - If that ID is already busy, the entry is still overwritten and `alloc_err_o` pulses.
- **Accept:** occurs on `mem_resp_valid_i & mem_resp_ready_o`.
  - If `busy[mem_resp_id_i]`: enqueue {payload, id, `table[id]`}. The table is read before any same-cycle write.
  - If `mem_resp_last_i` is also set, clear `busy[id]`.
  - If the ID is not busy: the beat is consumed and not enqueued, and `unexp_err_o` pulses.
- **Multi-beat responses:** non-last beats leave the entry busy and each is routed with the same select.
- **Same-ID free and allocate in one cycle:**
  - The response beat uses the old port ID.
  - Final state: busy=1 with the new port ID.
  - No `alloc_err_o` is raised.
- **Counter:** `outstanding_o` = popcount of busy. It is maintained as a counter: +1 on allocate of a non-busy ID, −1 on free, net 0 when both occur. A reallocation of a busy ID does not increment.
- **FIFO:**
  - 2 entries, in-order.
  - Head entry drives `resp_*_o`; pop on `resp_valid_o & resp_ready_i`.
  - Push and pop in the same cycle are allowed at any occupancy, including full, provided `mem_resp_ready_o` was 1.
- **`mem_resp_ready_o`:** equals `count != 2` and comes from registered state only. There is no combinational path from `resp_ready_i`.

## Timing
- Reset values:
  - `mem_resp_ready_o`=1.
  - `resp_valid_o`=0; `resp_o`, `resp_id_o`, `resp_sel_o`=0.
  - `id_busy_o`=0, `outstanding_o`=0.
  - `alloc_err_o`=0, `unexp_err_o`=0.
  - Table contents = 0.
- Reset mid-operation clears the FIFO, busy flags and counter immediately (asynchronous). In-flight responses are lost.
- **Latency:** 1 cycle from input handshake to `resp_valid_o` when the FIFO is empty.
- **Throughput:** 1 beat/cycle sustained while `resp_ready_i`=1.
- **Allocation timing:**
  - An allocation is visible in `id_busy_o` and `outstanding_o` the next cycle.
  - A response for an ID allocated in the same cycle is unexpected, because the table is read before the write.
- **Error pulses:** both are registered, asserted the cycle after the event, and last exactly one cycle per event.
- **Output stability:** `resp_*_o` stay stable while `resp_valid_o & !resp_ready_i`.
- **Full FIFO:** when count=2 and `resp_ready_i`=0, `mem_resp_ready_o`=0 next cycle and no input is accepted.

## Test plan
- **Single transaction:** allocate id 3 port 1; then response id 3 last=1, payload 0xA5. Required:
  - `resp_valid_o` 1 cycle later with `resp_sel_o`=1, `resp_id_o`=3, `resp_o`=0xA5.
  - busy[3] clears and `outstanding_o` returns 0.
- **Multi-beat:** allocate id 5 port 0; 4 beats, last on beat 4. Required:
  - All 4 beats are output with sel=0.
  - busy[5] stays 1 until the beat-4 handshake, then clears.
- **Backpressure:** `resp_ready_i`=0, push 3 beats. Required:
  - 2 beats are accepted; `mem_resp_ready_o`=0 after the second.
  - Releasing ready drains the beats in order, and the third beat is accepted on the next cycle.
- **Unexpected ID:** response id 7 with no allocation. Required:
  - The beat is consumed and `resp_valid_o` stays 0.
  - `unexp_err_o` pulses once.
- **Double allocation:** allocate id 2 port 0, then id 2 port 1. Required:
  - `alloc_err_o` pulses once and `outstanding_o`=1.
  - The following response for id 2 routes with sel=1.
- **Same-cycle free/allocate and reset:**
  - Last beat of id 4 (port 0) arriving together with allocation of id 4 to port 1. Required: that beat routes sel=0; busy[4]=1; the next response routes sel=1.
  - Assert `rst_ni` with 2 entries queued. Required: all outputs return to their reset values at once.
